// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared encodings for the multiply/divide engine.
//   md_op_e    : operation select (MULT, MULTU, DIV, DIVU)
//   md_state_e : sequencer states (IDLE, MUL, DIV, FIX)
package muldiv_unit_pkg;

    localparam int MD_OP_LENGTH = 2;

    typedef enum logic [MD_OP_LENGTH-1:0] {
        MD_OP_MULT  = 2'b00,
        MD_OP_MULTU = 2'b01,
        MD_OP_DIV   = 2'b10,
        MD_OP_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_FIX  = 2'd3
    } md_state_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: EX-stage <-> multiply/divide engine bundle.
//   master (EX stage)  drives : start, op, srcA, srcB, flush
//                      reads  : stall_req, busy, done, div_by_zero, hi, lo
//   slave  (engine)    mirror image of master
interface muldiv_unit_if
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic                    start;
    logic [MD_OP_LENGTH-1:0] op;
    logic [WIDTH-1:0]        srcA;
    logic [WIDTH-1:0]        srcB;
    logic                    flush;
    logic                    stall_req;
    logic                    busy;
    logic                    done;
    logic                    div_by_zero;
    logic [WIDTH-1:0]        hi;
    logic [WIDTH-1:0]        lo;

    modport master (
        output start, op, srcA, srcB, flush,
        input  stall_req, busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, srcA, srcB, flush,
        output stall_req, busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_unit_div_step.sv
// muldiv_unit_div_step: one combinational restoring-divide iteration.
//   rem      in  WIDTH  partial remainder (always < divisor)
//   quo      in  WIDTH  dividend bits still to shift in (MSB first), quotient bits shifted in at LSB
//   divisor  in  WIDTH  divisor magnitude
//   rem_next out WIDTH  updated partial remainder
//   quo_next out WIDTH  quo shifted left with the new quotient bit
module muldiv_unit_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {rem, quo[WIDTH-1]};
    assign diff    = shifted - {1'b0, divisor};

    // Because rem < divisor, shifted < 2*divisor, so diff[WIDTH] is exactly
    // the borrow: set means the trial subtraction must be undone.
    assign rem_next = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], ~diff[WIDTH]};
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide engine with architectural HI/LO.
//   clk   in  clock, rising edge
//   rst   in  asynchronous active-low reset
//   bus   slave modport of muldiv_unit_if:
//         start/op/srcA/srcB/flush in; stall_req (comb), busy, done,
//         div_by_zero, hi, lo out (registered)
// Build option: MULDIV_FAST_MUL_EN selects a single-cycle combinational
// multiplier (IDLE -> FIX -> IDLE); divide is always iterative.
// CNT_W must satisfy 2**CNT_W > WIDTH.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_unit_if.slave  bus
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    md_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc_hi;   // product high / partial remainder
    logic [WIDTH-1:0] acc_lo;   // multiplier->product low / dividend->quotient
    logic [WIDTH-1:0] mcand;    // multiplicand or divisor magnitude
    logic             neg_lo;   // sign of product / quotient
    logic             neg_hi;   // sign of remainder (dividend sign)
    logic             is_div_q;
    logic             dz_q;
    logic             busy_q, done_q, dbz_q;
    logic [WIDTH-1:0] hi_q, lo_q;

    // Operand decode and magnitude conversion
    logic             signed_op, is_div, src_b_zero, sign_a, sign_b;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign signed_op  = (bus.op == MD_OP_MULT) || (bus.op == MD_OP_DIV);
    assign is_div     = (bus.op == MD_OP_DIV)  || (bus.op == MD_OP_DIVU);
    assign src_b_zero = (bus.srcB == '0);
    assign sign_a     = signed_op & bus.srcA[WIDTH-1];
    assign sign_b     = signed_op & bus.srcB[WIDTH-1];
    assign mag_a      = sign_a ? -bus.srcA : bus.srcA;
    assign mag_b      = sign_b ? -bus.srcB : bus.srcB;

    // Shift-add multiply step: add multiplicand when the multiplier LSB is
    // set, then shift the {acc_hi, acc_lo} pair right by one.
    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);

    logic [WIDTH-1:0] div_rem, div_quo;
    muldiv_unit_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem      (acc_hi),
        .quo      (acc_lo),
        .divisor  (mcand),
        .rem_next (div_rem),
        .quo_next (div_quo)
    );

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`endif

    // Sign fix-up applied in FIX. Most-negative / -1 falls out naturally:
    // the quotient magnitude 2**(WIDTH-1) stays positive and wraps.
    logic [2*WIDTH-1:0] prod, prod_neg;
    logic [WIDTH-1:0]   fix_hi, fix_lo;
    assign prod     = {acc_hi, acc_lo};
    assign prod_neg = -prod;
    assign fix_hi   = is_div_q ? (neg_hi ? -acc_hi : acc_hi)
                               : (neg_lo ? prod_neg[2*WIDTH-1:WIDTH] : acc_hi);
    assign fix_lo   = is_div_q ? (neg_lo ? -acc_lo : acc_lo)
                               : (neg_lo ? prod_neg[WIDTH-1:0] : acc_lo);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= MD_IDLE;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            mcand    <= '0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            is_div_q <= 1'b0;
            dz_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            if (bus.flush) begin
                // Abort from any state; also beats a simultaneous start.
                state  <= MD_IDLE;
                busy_q <= 1'b0;
                cnt    <= '0;
            end else begin
                case (state)
                    MD_IDLE: begin
                        if (bus.start) begin
                            acc_hi   <= '0;
                            acc_lo   <= mag_a;
                            mcand    <= mag_b;
                            neg_lo   <= sign_a ^ sign_b;
                            neg_hi   <= sign_a;
                            is_div_q <= is_div;
                            dz_q     <= is_div & src_b_zero;
                            cnt      <= '0;
                            busy_q   <= 1'b1;
                            if (is_div && src_b_zero)
                                state <= MD_FIX;
                            else if (is_div)
                                state <= MD_DIV;
                            else begin
`ifdef MULDIV_FAST_MUL_EN
                                {acc_hi, acc_lo} <= fast_prod;
                                state            <= MD_FIX;
`else
                                state <= MD_MUL;
`endif
                            end
                        end
                    end
                    MD_MUL: begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                        cnt    <= cnt + CNT_W'(1);
                        if (cnt == LAST) state <= MD_FIX;
                    end
                    MD_DIV: begin
                        acc_hi <= div_rem;
                        acc_lo <= div_quo;
                        cnt    <= cnt + CNT_W'(1);
                        if (cnt == LAST) state <= MD_FIX;
                    end
                    MD_FIX: begin
                        state  <= MD_IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        dbz_q  <= dz_q;
                        if (!dz_q) begin
                            hi_q <= fix_hi;
                            lo_q <= fix_lo;
                        end
                    end
                    default: state <= MD_IDLE;
                endcase
            end
        end
    end

    // Combinational so the start cycle itself is frozen; drops in the done
    // cycle so the consuming instruction advances exactly once.
    assign bus.stall_req   = (bus.start & (state == MD_IDLE)) | busy_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit. Expected HI/LO come from
// native SV arithmetic at stimulus time and are checked when done pulses.
// Honours MULDIV_FAST_MUL_EN for expected multiply latency.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    int           n_vec = 0;
    int           n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        longint      sa, sbv, q, r;
        logic [63:0] p, qv, rv;
        sa    = longint'($signed(a));
        sbv   = longint'($signed(b));
        e.hi  = m_hi;
        e.lo  = m_lo;
        e.dbz = 1'b0;
        e.lat = W + 2;
        case (op)
            MD_OP_MULT: begin
                p    = sa * sbv;
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            MD_OP_MULTU: begin
                p    = {32'b0, a} * {32'b0, b};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            MD_OP_DIV: begin
                if (b == '0) begin
                    e.dbz = 1'b1;
                    e.lat = 2;
                end else begin
                    q    = sa / sbv;
                    r    = sa % sbv;
                    qv   = q;
                    rv   = r;
                    e.lo = qv[31:0];
                    e.hi = rv[31:0];
                end
            end
            default: begin
                if (b == '0) begin
                    e.dbz = 1'b1;
                    e.lat = 2;
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
`ifdef MULDIV_FAST_MUL_EN
        if (!op[1]) e.lat = 2;
`endif
        return e;
    endfunction

    // Issue one op, follow it to done and score it. poke re-asserts start
    // mid-operation with different operands, which must be ignored.
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
        exp_t e, g;
        int   lat, stl;
        e = model(op, a, b);
        m_hi = e.hi;
        m_lo = e.lo;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.srcA  = a;
        bus.srcB  = b;
        #1;
        stl = bus.stall_req ? 1 : 0;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = ~op;
        bus.srcA  = ~a;
        bus.srcB  = b ^ 32'h0000_5a5a;
        lat = 1;
        forever begin
            if (bus.done || lat >= 100) break;
            if (bus.stall_req) stl++;
            if (poke) bus.start = (lat == 5);
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        g = sb.pop_front();
        if (!bus.done) begin
            chk({tag, ".timeout"}, 64'(bus.done), 64'd1);
            return;
        end
        chk({tag, ".hi"},      64'(bus.hi), 64'(g.hi));
        chk({tag, ".lo"},      64'(bus.lo), 64'(g.lo));
        chk({tag, ".dbz"},     64'(bus.div_by_zero), 64'(g.dbz));
        chk({tag, ".latency"}, 64'(lat), 64'(g.lat));
        chk({tag, ".stall_cycles"}, 64'(stl), 64'(g.lat));
        chk({tag, ".stall_at_done"}, 64'(bus.stall_req), 64'd0);
        @(negedge clk);
        chk({tag, ".done_pulse"}, 64'(bus.done), 64'd0);
        chk({tag, ".idle_busy"},  64'(bus.busy), 64'd0);
    endtask

    // Watch a window of cycles for a spurious done, then check HI/LO held.
    task automatic quiet_window(input string tag);
        bit seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        chk({tag, ".no_done"}, 64'(seen), 64'd0);
        chk({tag, ".hi_held"}, 64'(bus.hi), 64'(m_hi));
        chk({tag, ".lo_held"}, 64'(bus.lo), 64'(m_lo));
    endtask

    initial begin
        logic [1:0]   rop;
        logic [W-1:0] ra, rb;

        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = '0;
        bus.srcA  = '0;
        bus.srcB  = '0;

        repeat (3) @(negedge clk);
        chk("rst.busy",  64'(bus.busy), 64'd0);
        chk("rst.done",  64'(bus.done), 64'd0);
        chk("rst.dbz",   64'(bus.div_by_zero), 64'd0);
        chk("rst.hi",    64'(bus.hi), 64'd0);
        chk("rst.lo",    64'(bus.lo), 64'd0);
        chk("rst.stall", 64'(bus.stall_req), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        run_op("mult_7x-3",    MD_OP_MULT,  32'd7, 32'hFFFF_FFFD, 1'b0);
        chk("mult_7x-3.hi_const", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);
        chk("mult_7x-3.lo_const", 64'(bus.lo), 64'h0000_0000_FFFF_FFEB);
        run_op("divu_100_7",   MD_OP_DIVU,  32'd100, 32'd7, 1'b0);
        chk("divu_100_7.lo_const", 64'(bus.lo), 64'd14);
        chk("divu_100_7.hi_const", 64'(bus.hi), 64'd2);
        run_op("div_-7_2",     MD_OP_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("div_min_-1",   MD_OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("div_min_-1.lo_const", 64'(bus.lo), 64'h8000_0000);
        run_op("div_7_-2",     MD_OP_DIV,   32'd7, 32'hFFFF_FFFE, 1'b0);
        run_op("multu_max",    MD_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("mult_min_min", MD_OP_MULT,  32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op("mult_poke",    MD_OP_MULT,  32'hFFFF_FF00, 32'd1234, 1'b1);
        run_op("div_poke",     MD_OP_DIV,   32'hFFFF_F000, 32'd77, 1'b1);
        run_op("divu_small",   MD_OP_DIVU,  32'd3, 32'hFFFF_FFFF, 1'b0);

        // Preload hi=5, lo=9, then divide by zero must leave them alone.
        run_op("divu_68_7",    MD_OP_DIVU,  32'd68, 32'd7, 1'b0);
        run_op("divu_by_0",    MD_OP_DIVU,  32'd1000, 32'd0, 1'b0);
        chk("divu_by_0.hi_const", 64'(bus.hi), 64'd5);
        chk("divu_by_0.lo_const", 64'(bus.lo), 64'd9);
        run_op("div_by_0",     MD_OP_DIV,   32'hFFFF_FFF0, 32'd0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            if (i % 4 == 1) rb = -rb;
            if (rb == '0) rb = 32'd1;
            run_op($sformatf("rand%0d", i), rop, ra, rb, 1'b0);
        end

        // Flush at cycle 10 of MULTU 3*4.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = MD_OP_MULTU;
        bus.srcA  = 32'd3;
        bus.srcB  = 32'd4;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        chk("flush.busy_before", 64'(bus.busy), 64'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush.busy_after",  64'(bus.busy), 64'd0);
        chk("flush.stall_after", 64'(bus.stall_req), 64'd0);
        quiet_window("flush");

        // start and flush together in IDLE: nothing starts.
        @(negedge clk);
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.op    = MD_OP_MULTU;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        chk("start_flush.busy", 64'(bus.busy), 64'd0);
        quiet_window("start_flush");

        // Async reset at cycle 5 of a DIV: outputs clear without a clock edge.
        run_op("pre_rst", MD_OP_MULTU, 32'h1234_5678, 32'h9abc_def0, 1'b0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = MD_OP_DIV;
        bus.srcA  = 32'd1000;
        bus.srcB  = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_rst.busy",  64'(bus.busy), 64'd0);
        chk("async_rst.done",  64'(bus.done), 64'd0);
        chk("async_rst.hi",    64'(bus.hi), 64'd0);
        chk("async_rst.lo",    64'(bus.lo), 64'd0);
        chk("async_rst.stall", 64'(bus.stall_req), 64'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        rst = 1'b1;
        run_op("post_rst_dz",   MD_OP_DIVU,  32'd5, 32'd0, 1'b0);
        run_op("post_rst_mult", MD_OP_MULTU, 32'd3, 32'd4, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
